nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry slice, one nibble per clock.
//   Operands arrive on a valid/ready input channel; the result leaves on a valid/ready output channel.
//   It sits in front of the nibble adder datapath. It sequences operand nibbles into the slice
//   and registers the slice's carry-out back into the next cycle's carry-in.
// PARAMETERS
//   WIDTH   16   operand/sum width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand request valid
//   in_ready   out  1      block can accept operands this cycle
//   a          in   WIDTH  operand A, sampled on accept
//   b          in   WIDTH  operand B, sampled on accept
//   cin        in   1      carry-in, sampled on accept
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  registered sum
//   cout       out  1      registered final carry-out
// BEHAVIOUR
//   - NIB = WIDTH/4. FSM states: IDLE, ADD, DONE. Nibble index counter is max($clog2(NIB),1) bits wide.
//   - Reset (async assert, sync release): state=IDLE; out_valid=0; sum=0; cout=0; index, carry and operand regs=0.
//   - in_ready is combinational: (state==IDLE) || (state==DONE && out_ready).
//   - Accept = in_valid && in_ready. On accept: latch a, b; carry<=cin; index<=0; state<=ADD; sum<=0.
//   - ADD, each cycle: slice adds a[4i+:4] + b[4i+:4] + carry, with i=index.
//       - sum[4i+:4] <= slice sum; carry <= slice c4; index++.
//       - On i==NIB-1: cout <= slice c4, out_valid<=1, state<=DONE.
//   - Latency: out_valid rises exactly NIB clocks after the accept edge (16-bit: 4 clocks).
//   - DONE: sum, cout and out_valid are held stable while out_ready=0.
//       - out_ready=1 with no accept: out_valid<=0, state<=IDLE.
//       - out_ready=1 with an accept in the same cycle: back-to-back. out_valid<=0, new operands
//         latched, state<=ADD. Sustained throughput is one result per NIB+1 clocks.
//   - In IDLE/ADD, in_valid is ignored; operand inputs may change freely during ADD.
//   - Arithmetic is unsigned modulo 2^WIDTH; cout is carry out of bit WIDTH-1.
//   - Reset asserted mid-ADD or in DONE aborts the operation: no out_valid, the partial sum is discarded.
// CONFIGURATION
//   SUB_MODE_EN defined:
//     - Adds input port `sub` (1 bit), sampled on accept.
//     - sub=1: result = a - b, using stored ~b and carry-in forced to 1 (cin ignored).
//     - cout=1 means no borrow (a >= b unsigned).
//   SUB_MODE_EN undefined: no `sub` port; behaviour is addition only, as above.
// STRUCTURE
//   - Package nibble_serial_adder_pkg: FSM state typedef (IDLE/ADD/DONE) and localparam NIBBLE_W=4.
//   - Sub-module nibble_add_slice: combinational 4-bit ripple-carry add (x, y, ci -> s[3:0], co).
//     One instance is shared across all nibbles. All sequencing, muxing and registers live in the top level.
// TESTING  (WIDTH=16 unless noted)
//   1 Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, sum=0, cout=0.
//   2 Basic add: a=16'h1234, b=16'h0FCD, cin=0 -> 4 clocks after accept: out_valid=1, sum=16'h2201, cout=0.
//   3 Full-width carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
//     Check that carry crosses every nibble boundary.
//   4 Backpressure, then back-to-back:
//       - Result 16'h0003 from 1+2: hold out_ready=0 for 5 clocks -> sum/cout stable, in_ready=0.
//       - Raise out_ready with in_valid=1 (a=16'h0005, b=16'h0006) -> accepted same cycle,
//         next result sum=16'h000B.
//   5 Abort: assert rst_n=0 two clocks into ADD -> out_valid never asserts, sum=0.
//     The next transaction completes correctly.
//   6 SUB_MODE_EN build: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0.
//     a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
//     Also run case 2 with WIDTH=4 and WIDTH=32 (latency 1 and 8).

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the width of the shared adder slice.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// Combinational 4-bit ripple-carry adder slice (module nibble_add_slice).
// The serial adder top level shares one instance across every nibble.
module nibble_add_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    co = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per clock through a shared 4-bit slice.
// Define SUB_MODE_EN to add the `sub` port (a - b via stored ~b and forced carry-in).
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;

  logic [NIBBLE_W-1:0] slice_x, slice_y, slice_s;
  logic                slice_co;
  logic                accept;
  logic [WIDTH-1:0]    b_load;
  logic                c_load;

  nibble_add_slice u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Subtraction is folded into the load: the datapath only ever adds.
`ifdef SUB_MODE_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    slice_x = '0;
    slice_y = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_x = a_q[i*NIBBLE_W +: NIBBLE_W];
        slice_y = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ADD: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_s;
          end
        end
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIB - 1)) begin
          cout_d      = slice_co;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // Covers both IDLE and the back-to-back handoff out of DONE.
    if (accept) begin
      a_d         = a;
      b_d         = b_load;
      carry_d     = c_load;
      idx_d       = '0;
      sum_d       = '0;
      out_valid_d = 1'b0;
      state_d     = ADD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random transactions
// checked against a plain-arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUB_MODE_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    if (ms) return {1'b0, ma} - {1'b0, mb} + (W+1)'(1 << W);
    return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Present operands with out_ready=1 so it also works as a back-to-back handoff.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
    logic [W:0] ex;
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1; out_ready = 1'b1;
    ex = model(ta, tb, tc, ts);
    exp_sum  = ex[W-1:0];
    exp_cout = ex[W];
    #1;
    chk("launch_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("accept_out_valid_low", out_valid, 0);
  endtask

  task automatic collect(input string tag);
    int lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid !== 1'b1 && lat < NIB + 4);
    chk({tag, "_latency"}, lat, NIB);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_cout"}, cout, exp_cout);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum", sum, exp_sum);
      chk("hold_cout", cout, exp_cout);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    logic seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);

    launch(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    collect("basic");
    drain();

    launch(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    collect("ripple");
    drain();

    launch(16'h0001, 16'h0002, 1'b0, 1'b0);
    collect("bp_first");
    hold(5);
    launch(16'h0005, 16'h0006, 1'b0, 1'b0);
    collect("b2b");
    drain();

    // Abort two clocks into ADD.
    launch(16'hABCD, 16'h1111, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < int'(NIB) + 2; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    chk("abort_no_valid", seen_valid, 0);
    chk("abort_sum_after", sum, 0);

    launch(16'h4321, 16'h1234, 1'b0, 1'b0);
    collect("post_abort");
    drain();

`ifdef SUB_MODE_EN
    launch(16'h0005, 16'h0007, 1'b0, 1'b1);
    collect("sub_neg");
    drain();
    launch(16'h0007, 16'h0005, 1'b1, 1'b1);
    collect("sub_pos");
    drain();
`endif

    for (int t = 0; t < 24; t++) begin
      logic rs;
      rs = 1'b0;
`ifdef SUB_MODE_EN
      rs = 1'($urandom);
`endif
      launch(W'($urandom), W'($urandom), 1'($urandom), rs);
      collect("rand");
      hold(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
